alarm_unit: RTL
===============

Name: alarm_unit

Overview:
- Downstream consumer of the multiplexed clock core's BCD time digits (hrs_d, hrs_u, min_d, min_u) and its second/minute pulses.
- Holds a user-settable alarm time and detects a match with the running time.
- Sequences IDLE / RINGING / SNOOZED and drives a buzzer square wave.
- Exposes the alarm digits so the display mux can show them in set mode.

Parameters:
- TONE_DIV, 8: clk cycles per buzzer half-period (32768 Hz / 16 = 2048 Hz tone).
- RING_SECONDS, 60: sec_tick pulses in RINGING before auto-off to IDLE.
- SNOOZE_MINUTES, 5: minute_tick pulses in SNOOZED before re-ringing.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- time_min_u  in  4  current minutes units, BCD 0-9
- time_min_d  in  4  current minutes tens, BCD 0-5
- time_hrs_u  in  4  current hours units, BCD 0-9
- time_hrs_d  in  4  current hours tens, BCD 0-2
- sec_tick  in  1  one-cycle pulse per second
- minute_tick  in  1  one-cycle pulse per minute rollover
- alarm_en  in  1  level; 0 disables triggering and forces IDLE
- set_mode  in  1  level; 1 means the adjust pulses edit the alarm time
- inc_min  in  1  one-cycle debounced pulse, increment alarm minute
- inc_hrs  in  1  one-cycle debounced pulse, increment alarm hour
- snooze  in  1  one-cycle pulse
- dismiss  in  1  one-cycle pulse
- alarm_min_u / alarm_min_d / alarm_hrs_u / alarm_hrs_d  out  4 each  stored alarm time, BCD
- ringing  out  1  high in RINGING
- snoozed  out  1  high in SNOOZED
- buzzer  out  1  tone output

Behaviour:
- Reset values:
  - alarm digits all 0 (00:00).
  - state IDLE; ringing=0, snoozed=0, buzzer=0.
  - match_q=1, so no trigger immediately after reset.
  - All counters 0.
- Match detection:
  - match = all four time digits equal the alarm digits. match_q registers match every cycle.
  - trigger = match & !match_q & alarm_en & !set_mode, i.e. rising edge only.
  - A dismissed alarm does not re-fire within the same minute.
- Alarm editing, only while set_mode=1:
  - inc_min: minutes step 00..59, then wrap to 00; no carry into hours.
  - inc_hrs: hours step 00..23, then wrap to 00.
  - inc_min and inc_hrs in the same cycle: both apply.
  - Pulses are ignored while set_mode=0.
- State machine (registered; outputs valid the cycle after the transition):
  - IDLE -> RINGING on trigger. ring_cnt cleared.
  - RINGING -> IDLE on dismiss.
  - RINGING -> SNOOZED on snooze. snz_cnt cleared.
  - RINGING -> IDLE when ring_cnt reaches RING_SECONDS. ring_cnt increments on sec_tick.
  - SNOOZED -> RINGING when snz_cnt reaches SNOOZE_MINUTES. snz_cnt increments on minute_tick; ring_cnt cleared on entry.
  - SNOOZED -> IDLE on dismiss.
  - Any state -> IDLE when alarm_en=0 or set_mode=1. This has priority over all other transitions.
  - dismiss and snooze in the same cycle: dismiss wins.
  - A trigger while RINGING or SNOOZED is ignored.
- Buzzer:
  - Tone counter runs only in RINGING and toggles tone every TONE_DIV cycles.
  - Outside RINGING, the counter and tone are held at 0, so buzzer=0 within 1 cycle of leaving RINGING.
- Widths:
  - ring_cnt is clog2(RING_SECONDS+1) bits; snz_cnt is clog2(SNOOZE_MINUTES+1) bits.
  - Counters saturate and never wrap.

Optional Feature:
- Macro: ALARM_BEEP_PATTERN_EN.
- When defined:
  - A beep_phase register is set to 1 on entry to RINGING and toggles on each sec_tick.
  - buzzer = tone & beep_phase, giving 1 s on / 1 s off.
- When undefined: buzzer = tone continuously while RINGING. No beep_phase register exists.

Decomposition:
- Package alarm_pkg:
  - state enum: ST_IDLE=2'd0, ST_RINGING=2'd1, ST_SNOOZED=2'd2.
  - BCD limits: MIN_D_MAX=5, UNITS_MAX=9, HRS_D_MAX=2, HRS_U_MAX_AT_2=3.
- One sub-module, alarm_tone_gen (TONE_DIV counter plus toggle, with enable and clear). Everything else stays in alarm_unit.

Test Plan:
- Reset, then hold time 00:00 with alarm 00:00 -> ringing stays 0; the match_q reset value suppresses a trigger.
- set_mode=1, inc_hrs x7, inc_min x30 -> alarm reads 07:30. Then 30 more inc_min -> 07:00, with hrs unchanged.
- set_mode=1, inc_hrs x24 from 00 -> hours wrap 23->00.
- Alarm 07:30, alarm_en=1; time goes 07:29 -> 07:30:
  - ringing=1 one cycle after the digit change.
  - buzzer period = 2*TONE_DIV = 16 cycles.
  - 60 sec_ticks later -> IDLE, buzzer=0.
- Ringing, snooze pulse -> snoozed=1, buzzer=0. After 5 minute_ticks -> ringing=1. Then dismiss and snooze in the same cycle -> IDLE.
- Ringing, set_mode raised -> IDLE next cycle. With ALARM_BEEP_PATTERN_EN defined: during ringing, buzzer is silent on alternate seconds.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types, BCD limits and BCD increment helpers for alarm_unit.
// Contents: alarm_state_e FSM encoding, bcd_time_t HH:MM payload,
//           bcd_min_inc / bcd_hrs_inc wrap-around digit steppers.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_e;

  localparam logic [3:0] MIN_D_MAX      = 4'd5;
  localparam logic [3:0] UNITS_MAX      = 4'd9;
  localparam logic [3:0] HRS_D_MAX      = 4'd2;
  localparam logic [3:0] HRS_U_MAX_AT_2 = 4'd3;

  // HH:MM as four BCD digits, most significant first
  typedef struct packed {
    logic [3:0] hrs_d;
    logic [3:0] hrs_u;
    logic [3:0] min_d;
    logic [3:0] min_u;
  } bcd_time_t;

  // Minutes 00..59 then back to 00; returns {tens, units}
  function automatic logic [7:0] bcd_min_inc(input logic [3:0] d, input logic [3:0] u);
    logic [7:0] r;
    if (u >= UNITS_MAX) begin
      r[3:0] = 4'd0;
      r[7:4] = (d >= MIN_D_MAX) ? 4'd0 : d + 4'd1;
    end else begin
      r = {d, u + 4'd1};
    end
    return r;
  endfunction

  // Hours 00..23 then back to 00; returns {tens, units}
  function automatic logic [7:0] bcd_hrs_inc(input logic [3:0] d, input logic [3:0] u);
    logic [7:0] r;
    if ((d >= HRS_D_MAX) && (u >= HRS_U_MAX_AT_2)) begin
      r = 8'h00;
    end else if (u >= UNITS_MAX) begin
      r = {d + 4'd1, 4'd0};
    end else begin
      r = {d, u + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// alarm_tone_gen: square-wave generator, tone toggles every TONE_DIV enabled cycles.
// Ports: clk, reset (async, active-high), en (advance counter),
//        clr (hold counter and tone at 0, wins over en), tone (registered output).
module alarm_tone_gen #(
  parameter int unsigned TONE_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tone
);

  localparam int unsigned CNT_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TONE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Half-period counter and tone toggle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alarm_unit.sv
// alarm_unit: settable BCD alarm time, match detection against the running clock,
// IDLE/RINGING/SNOOZED sequencing and buzzer tone output.
// Ports: clk, reset (async, active-high); time_{hrs,min}_{d,u} current time (BCD);
//        sec_tick/minute_tick pulses; alarm_en, set_mode levels; inc_min, inc_hrs,
//        snooze, dismiss pulses; alarm_{hrs,min}_{d,u} stored alarm time;
//        ringing, snoozed status; buzzer tone.
// Build option: define ALARM_BEEP_PATTERN_EN to gate the tone 1 s on / 1 s off.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int unsigned TONE_DIV       = 8,
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] time_min_u,
  input  logic [3:0] time_min_d,
  input  logic [3:0] time_hrs_u,
  input  logic [3:0] time_hrs_d,
  input  logic       sec_tick,
  input  logic       minute_tick,
  input  logic       alarm_en,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hrs,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [3:0] alarm_min_u,
  output logic [3:0] alarm_min_d,
  output logic [3:0] alarm_hrs_u,
  output logic [3:0] alarm_hrs_d,
  output logic       ringing,
  output logic       snoozed,
  output logic       buzzer
);

  localparam int unsigned RING_W = $clog2(RING_SECONDS + 1);
  localparam int unsigned SNZ_W  = $clog2(SNOOZE_MINUTES + 1);
  localparam logic [RING_W-1:0] RING_MAX = RING_W'(RING_SECONDS);
  localparam logic [SNZ_W-1:0]  SNZ_MAX  = SNZ_W'(SNOOZE_MINUTES);

  bcd_time_t         alarm_q;
  bcd_time_t         now;
  alarm_state_e      state;
  logic [RING_W-1:0] ring_cnt;
  logic [SNZ_W-1:0]  snz_cnt;
  logic              match;
  logic              match_q;
  logic              trigger;
  logic              force_idle;
  logic              tone;
`ifdef ALARM_BEEP_PATTERN_EN
  logic              beep_phase;
`endif

  assign now        = '{hrs_d: time_hrs_d, hrs_u: time_hrs_u, min_d: time_min_d, min_u: time_min_u};
  assign match      = (now == alarm_q);
  // Rising edge of match only, so a dismissed alarm stays quiet for the rest of the minute
  assign trigger    = match & ~match_q & alarm_en & ~set_mode;
  assign force_idle = ~alarm_en | set_mode;

  // Alarm time editing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_q <= '0;
    end else if (set_mode) begin
      if (inc_min) {alarm_q.min_d, alarm_q.min_u} <= bcd_min_inc(alarm_q.min_d, alarm_q.min_u);
      if (inc_hrs) {alarm_q.hrs_d, alarm_q.hrs_u} <= bcd_hrs_inc(alarm_q.hrs_d, alarm_q.hrs_u);
    end
  end

  // Alarm state machine with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ringing  <= 1'b0;
      snoozed  <= 1'b0;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      match_q  <= 1'b1;
`ifdef ALARM_BEEP_PATTERN_EN
      beep_phase <= 1'b0;
`endif
    end else begin
      match_q <= match;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state    <= ST_RINGING;
            ringing  <= 1'b1;
            ring_cnt <= '0;
`ifdef ALARM_BEEP_PATTERN_EN
            beep_phase <= 1'b1;
`endif
          end
        end
        ST_RINGING: begin
`ifdef ALARM_BEEP_PATTERN_EN
          if (sec_tick) beep_phase <= ~beep_phase;
`endif
          if (dismiss) begin
            state   <= ST_IDLE;
            ringing <= 1'b0;
          end else if (snooze) begin
            state   <= ST_SNOOZED;
            ringing <= 1'b0;
            snoozed <= 1'b1;
            snz_cnt <= '0;
          end else if (ring_cnt == RING_MAX) begin
            state   <= ST_IDLE;
            ringing <= 1'b0;
          end else if (sec_tick) begin
            ring_cnt <= ring_cnt + RING_W'(1);
          end
        end
        ST_SNOOZED: begin
          if (dismiss) begin
            state   <= ST_IDLE;
            snoozed <= 1'b0;
          end else if (snz_cnt == SNZ_MAX) begin
            state    <= ST_RINGING;
            snoozed  <= 1'b0;
            ringing  <= 1'b1;
            ring_cnt <= '0;
`ifdef ALARM_BEEP_PATTERN_EN
            beep_phase <= 1'b1;
`endif
          end else if (minute_tick) begin
            snz_cnt <= snz_cnt + SNZ_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          ringing <= 1'b0;
          snoozed <= 1'b0;
        end
      endcase
      // Disable or set mode overrides every transition above
      if (force_idle) begin
        state   <= ST_IDLE;
        ringing <= 1'b0;
        snoozed <= 1'b0;
      end
    end
  end

  alarm_tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_RINGING),
    .clr   (state != ST_RINGING),
    .tone  (tone)
  );

`ifdef ALARM_BEEP_PATTERN_EN
  assign buzzer = tone & beep_phase;
`else
  assign buzzer = tone;
`endif

  assign alarm_min_u = alarm_q.min_u;
  assign alarm_min_d = alarm_q.min_d;
  assign alarm_hrs_u = alarm_q.hrs_u;
  assign alarm_hrs_d = alarm_q.hrs_d;

endmodule
